// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_pkg
//  Description : Shared constants for the multi-cycle MIPS ALU control slice:
//                ALUOp classes, R-type funct codes, ALUOperation codes,
//                mul/div sequencer state encodings and the selector decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_ctrl_pkg;

  // ALUOp classes (low 3 bits of ALUOp)
  localparam logic [2:0] C_OP_LWSW   = 3'b000;
  localparam logic [2:0] C_OP_BRANCH = 3'b001;
  localparam logic [2:0] C_OP_ADDI   = 3'b100;
  localparam logic [2:0] C_OP_ORI    = 3'b101;
  localparam logic [2:0] C_OP_LUI    = 3'b110;
  localparam logic [2:0] C_OP_RTYPE  = 3'b111;

  // R-type funct field values
  localparam logic [5:0] C_FN_AND  = 6'b100100;
  localparam logic [5:0] C_FN_OR   = 6'b100101;
  localparam logic [5:0] C_FN_NOR  = 6'b100111;
  localparam logic [5:0] C_FN_ADD  = 6'b100000;
  localparam logic [5:0] C_FN_SUB  = 6'b100010;
  localparam logic [5:0] C_FN_SLL  = 6'b000000;
  localparam logic [5:0] C_FN_SRL  = 6'b000010;
  localparam logic [5:0] C_FN_SLT  = 6'b101010;
  localparam logic [5:0] C_FN_MULT = 6'b011000;
  localparam logic [5:0] C_FN_DIV  = 6'b011010;
  localparam logic [5:0] C_FN_MFHI = 6'b010000;
  localparam logic [5:0] C_FN_MFLO = 6'b010010;

  // ALUOperation codes
  localparam logic [3:0] C_ALU_AND     = 4'b0000;
  localparam logic [3:0] C_ALU_OR      = 4'b0001;
  localparam logic [3:0] C_ALU_NOR     = 4'b0010;
  localparam logic [3:0] C_ALU_ADD     = 4'b0011;
  localparam logic [3:0] C_ALU_SUB     = 4'b0100;
  localparam logic [3:0] C_ALU_SLL     = 4'b0101;
  localparam logic [3:0] C_ALU_SRL     = 4'b0110;
  localparam logic [3:0] C_ALU_LUI     = 4'b0111;
  localparam logic [3:0] C_ALU_MULT    = 4'b1000;
  localparam logic [3:0] C_ALU_ILLEGAL = 4'b1001;
  localparam logic [3:0] C_ALU_DIV     = 4'b1010;
  localparam logic [3:0] C_ALU_MFHI    = 4'b1011;
  localparam logic [3:0] C_ALU_MFLO    = 4'b1100;
  localparam logic [3:0] C_ALU_SLT     = 4'b1101;

  // Mul/div sequencer states
  localparam logic [1:0] C_ST_IDLE    = 2'd0;
  localparam logic [1:0] C_ST_MD_RUN  = 2'd1;
  localparam logic [1:0] C_ST_MD_DONE = 2'd2;

  typedef struct packed {
    logic       legal;
    logic       muldiv;
    logic [3:0] code;
  } dec_t;

  // Map the low selector bits onto an ALU code; unknown selectors come back
  // with legal=0 and the reserved code.
  function automatic dec_t alu_decode(input logic [2:0] op, input logic [5:0] fn);
    dec_t d;
    d.legal  = 1'b1;
    d.muldiv = 1'b0;
    d.code   = C_ALU_ILLEGAL;
    case (op)
      C_OP_LWSW:   d.code = C_ALU_ADD;
      C_OP_BRANCH: d.code = C_ALU_SUB;
      C_OP_ADDI:   d.code = C_ALU_ADD;
      C_OP_ORI:    d.code = C_ALU_OR;
      C_OP_LUI:    d.code = C_ALU_LUI;
      C_OP_RTYPE: begin
        case (fn)
          C_FN_AND:  d.code = C_ALU_AND;
          C_FN_OR:   d.code = C_ALU_OR;
          C_FN_NOR:  d.code = C_ALU_NOR;
          C_FN_ADD:  d.code = C_ALU_ADD;
          C_FN_SUB:  d.code = C_ALU_SUB;
          C_FN_SLL:  d.code = C_ALU_SLL;
          C_FN_SRL:  d.code = C_ALU_SRL;
          C_FN_SLT:  d.code = C_ALU_SLT;
          C_FN_MULT: begin d.code = C_ALU_MULT; d.muldiv = 1'b1; end
          C_FN_DIV:  begin d.code = C_ALU_DIV;  d.muldiv = 1'b1; end
          C_FN_MFHI: d.code = C_ALU_MFHI;
          C_FN_MFLO: d.code = C_ALU_MFLO;
          default:   d.legal = 1'b0;
        endcase
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : md_sequencer
//  Description : Launch/stall/write-back sequencer for the iterative mul/div
//                unit. One launch cycle (md_start) followed by MD_CYCLES
//                iteration cycles, all stalled, then a single hilo_we cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module md_sequencer #(
  parameter int MD_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,      // asynchronous, active-low
  input  logic go,
  input  logic flush,
  output logic md_start,
  output logic stall,
  output logic hilo_we
);
  import alu_ctrl_pkg::*;

  localparam int            CW         = $clog2(MD_CYCLES + 1);
  localparam logic [CW-1:0] C_CNT_LOAD = CW'(MD_CYCLES - 1);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_md_start;

  // State/counter update; the launch cycle is spent handing operands to the
  // unit, so the iteration count only starts running after it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= C_ST_IDLE;
      r_cnt      <= '0;
      r_md_start <= 1'b0;
    end else begin
      r_md_start <= 1'b0;
      case (r_state)
        C_ST_IDLE: begin
          if (go) begin
            r_state    <= C_ST_MD_RUN;
            r_cnt      <= C_CNT_LOAD;
            r_md_start <= 1'b1;
          end
        end
        C_ST_MD_RUN: begin
          if (flush) begin
            r_state <= C_ST_IDLE;
            r_cnt   <= '0;
          end else if (!r_md_start) begin
            if (r_cnt == '0) begin
              r_state <= C_ST_MD_DONE;
            end else begin
              r_cnt <= r_cnt - C_CNT_ONE;
            end
          end
        end
        C_ST_MD_DONE: r_state <= C_ST_IDLE;
        default:      r_state <= C_ST_IDLE;
      endcase
    end
  end

  assign md_start = r_md_start;
  assign stall    = (r_state == C_ST_MD_RUN);
  assign hilo_we  = (r_state == C_ST_MD_DONE);

endmodule
`default_nettype wire

// File: rtl/alu_control_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_control_seq
//  Description : Registered ALU control for the multi-cycle MIPS datapath.
//                Decodes {ALUOp, ALUFunction} into ALUOperation and drives the
//                mul/div sequencer (md_start, stall, hilo_we).
//                Build option ILLEGAL_TRAP_EN: illegal selectors set a sticky
//                `illegal` flag and leave ALUOperation untouched.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_control_seq #(
  parameter int ALUOP_WIDTH = 3,
  parameter int FUNCT_WIDTH = 6,
  parameter int OPER_WIDTH  = 4,
  parameter int MD_CYCLES   = 32
) (
  input  logic                   clk,
  input  logic                   reset,       // asynchronous, active-low
  input  logic                   dec_valid,
  input  logic                   flush,
  input  logic [ALUOP_WIDTH-1:0] ALUOp,
  input  logic [FUNCT_WIDTH-1:0] ALUFunction,
  output logic [OPER_WIDTH-1:0]  ALUOperation,
  output logic                   op_valid,
  output logic                   md_start,
  output logic                   stall,
  output logic                   hilo_we,
  output logic                   illegal
);
  import alu_ctrl_pkg::*;

  localparam logic [OPER_WIDTH-1:0] C_RESET_OP = OPER_WIDTH'(C_ALU_ILLEGAL);

  dec_t                  w_dec;
  logic                  w_sel_legal;
  logic [3:0]            w_code;
  logic                  w_accept;
  logic                  w_go;
  logic                  w_stall;
  logic [OPER_WIDTH-1:0] r_op;
  logic                  r_op_valid;

  // Any set bit above the three class bits makes the whole selector illegal.
  assign w_dec       = alu_decode(ALUOp[2:0], ALUFunction[5:0]);
  assign w_sel_legal = w_dec.legal & ((ALUOp >> 3) == '0);
  assign w_code      = w_sel_legal ? w_dec.code : C_ALU_ILLEGAL;
  // Upstream holds its inputs while stalled, so nothing is decoded then.
  assign w_accept    = dec_valid & ~w_stall;
  assign w_go        = w_accept & w_sel_legal & w_dec.muldiv;

  md_sequencer #(
    .MD_CYCLES (MD_CYCLES)
  ) u_md_seq (
    .clk      (clk),
    .reset    (reset),
    .go       (w_go),
    .flush    (flush),
    .md_start (md_start),
    .stall    (w_stall),
    .hilo_we  (hilo_we)
  );

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;

  // Register the decoded op; an illegal selector only raises the sticky flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op       <= C_RESET_OP;
      r_op_valid <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_op_valid <= 1'b0;
      if (w_accept) begin
        if (!w_sel_legal) begin
          r_illegal <= 1'b1;
        end else begin
          r_op       <= OPER_WIDTH'(w_code);
          r_op_valid <= 1'b1;
        end
      end
    end
  end

  assign illegal = r_illegal;
`else
  // Register the decoded op; illegal selectors pass through as the reserved code.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op       <= C_RESET_OP;
      r_op_valid <= 1'b0;
    end else begin
      r_op_valid <= 1'b0;
      if (w_accept) begin
        r_op       <= OPER_WIDTH'(w_code);
        r_op_valid <= 1'b1;
      end
    end
  end

  assign illegal = 1'b0;
`endif

  assign ALUOperation = r_op;
  assign op_valid     = r_op_valid;
  assign stall        = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_alu_control_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_control_seq
//  Description : Self-checking bench for alu_control_seq. DUT A (4-bit ALUOp,
//                MD_CYCLES=4) runs directed and random traffic against a
//                behavioural model; DUT B (MD_CYCLES=1) checks the short run.
//                Honours ILLEGAL_TRAP_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_control_seq;

  localparam int MDA = 4;
  localparam int MDB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       a_dv, a_fl;
  logic [3:0] a_op;
  logic [5:0] a_fn;
  logic [3:0] a_alu;
  logic       a_ov, a_ms, a_st, a_hw, a_il;

  logic       b_dv, b_fl;
  logic [2:0] b_op;
  logic [5:0] b_fn;
  logic [3:0] b_alu;
  logic       b_ov, b_ms, b_st, b_hw, b_il;

  alu_control_seq #(.ALUOP_WIDTH(4), .FUNCT_WIDTH(6), .OPER_WIDTH(4), .MD_CYCLES(MDA)) u_dut_a (
    .clk(clk), .reset(reset), .dec_valid(a_dv), .flush(a_fl), .ALUOp(a_op), .ALUFunction(a_fn),
    .ALUOperation(a_alu), .op_valid(a_ov), .md_start(a_ms), .stall(a_st), .hilo_we(a_hw), .illegal(a_il)
  );

  alu_control_seq #(.ALUOP_WIDTH(3), .FUNCT_WIDTH(6), .OPER_WIDTH(4), .MD_CYCLES(MDB)) u_dut_b (
    .clk(clk), .reset(reset), .dec_valid(b_dv), .flush(b_fl), .ALUOp(b_op), .ALUFunction(b_fn),
    .ALUOperation(b_alu), .op_valid(b_ov), .md_start(b_ms), .stall(b_st), .hilo_we(b_hw), .illegal(b_il)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Selector table: returns the ALU code, or -1 for an unsupported selector.
  function automatic int ref_code(input logic [3:0] op, input logic [5:0] fn);
    if (op > 4'd7) return -1;
    case (op)
      4'd0: return 3;
      4'd1: return 4;
      4'd4: return 3;
      4'd5: return 1;
      4'd6: return 7;
      4'd7: begin
        case (fn)
          6'b100100: return 0;
          6'b100101: return 1;
          6'b100111: return 2;
          6'b100000: return 3;
          6'b100010: return 4;
          6'b000000: return 5;
          6'b000010: return 6;
          6'b101010: return 13;
          6'b011000: return 8;
          6'b011010: return 10;
          6'b010000: return 11;
          6'b010010: return 12;
          default:   return -1;
        endcase
      end
      default: return -1;
    endcase
  endfunction

  // Behavioural model of DUT A: m_rem = stall cycles still to come,
  // including the current one.
  int         m_rem = 0;
  logic [3:0] m_op  = 4'b1001;
  bit         m_ov  = 1'b0;
  bit         m_ms  = 1'b0;
  bit         m_hw  = 1'b0;
  bit         m_il  = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rem = 0; m_op = 4'b1001; m_ov = 1'b0; m_ms = 1'b0; m_hw = 1'b0; m_il = 1'b0;
    end else begin
      int code;
      bit was_hw;
      code   = ref_code(a_op, a_fn);
      was_hw = m_hw;
      m_hw   = (m_rem == 1) && !a_fl;
      m_ms   = 1'b0;
      m_ov   = 1'b0;
      if (m_rem > 0) begin
        m_rem = a_fl ? 0 : m_rem - 1;
      end else if (a_dv) begin
        if ((code == 8 || code == 10) && !was_hw) begin
          m_rem = MDA + 1;
          m_ms  = 1'b1;
        end
        if (code < 0) begin
`ifdef ILLEGAL_TRAP_EN
          m_il = 1'b1;
`else
          m_op = 4'b1001;
          m_ov = 1'b1;
`endif
        end else begin
          m_op = code[3:0];
          m_ov = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of DUT A against the model.
  always @(negedge clk) begin
    chk("cmp_ALUOperation", a_alu, m_op);
    chk("cmp_op_valid", a_ov, m_ov);
    chk("cmp_md_start", a_ms, m_ms);
    chk("cmp_stall", a_st, (m_rem > 0) ? 1 : 0);
    chk("cmp_hilo_we", a_hw, m_hw);
    chk("cmp_illegal", a_il, m_il);
  end

  task automatic drive_a(input bit dv, input logic [3:0] op, input logic [5:0] fn, input bit fl);
    a_dv = dv; a_op = op; a_fn = fn; a_fl = fl;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [5:0] fns [12] = '{6'b100100, 6'b100101, 6'b100111, 6'b100000, 6'b100010, 6'b000000,
                           6'b000010, 6'b101010, 6'b011000, 6'b011010, 6'b010000, 6'b010010};
  logic [3:0] t2_op  [3] = '{4'b0110, 4'b0001, 4'b0000};
  int         t2_exp [3] = '{7, 4, 3};

  initial begin
    reset = 1'b1;
    drive_a(0, 4'b0, 6'b0, 0);
    b_dv = 1'b0; b_fl = 1'b0; b_op = 3'b0; b_fn = 6'b0;
    #1 reset = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_ALUOperation", a_alu, 9);
    chk("rst_op_valid", a_ov, 0);
    chk("rst_stall", a_st, 0);
    chk("rst_hilo_we", a_hw, 0);
    chk("rst_illegal", a_il, 0);
    reset = 1'b1;
    tick();

    // R-type ADD decodes one cycle after the dec_valid sample
    drive_a(1, 4'b0111, 6'b100000, 0); tick();
    chk("t1_add_code", a_alu, 3);
    chk("t1_add_valid", a_ov, 1);
    drive_a(0, 4'b0111, 6'b100000, 0); tick();
    chk("t1_valid_pulse", a_ov, 0);
    chk("t1_code_hold", a_alu, 3);

    // Non-R classes
    for (int i = 0; i < 3; i++) begin
      drive_a(1, t2_op[i], 6'b101010, 0); tick();
      chk("t2_class_code", a_alu, t2_exp[i]);
      chk("t2_class_valid", a_ov, 1);
    end

    // MULT with MD_CYCLES=4: md_start t+1, stall t+1..t+5, hilo_we t+6
    drive_a(1, 4'b0111, 6'b011000, 0); tick();
    chk("t3_mult_code", a_alu, 8);
    for (int k = 1; k <= 7; k++) begin
      chk("t3_md_start", a_ms, (k == 1) ? 1 : 0);
      chk("t3_stall", a_st, (k <= 5) ? 1 : 0);
      chk("t3_hilo_we", a_hw, (k == 6) ? 1 : 0);
      drive_a(0, 4'b0111, 6'b011000, 0); tick();
    end

    // DIV flushed on its second stall cycle
    drive_a(1, 4'b0111, 6'b011010, 0); tick();
    chk("t4_div_code", a_alu, 10);
    chk("t4_stall1", a_st, 1);
    drive_a(0, 4'b0111, 6'b011010, 0); tick();
    chk("t4_stall2", a_st, 1);
    drive_a(0, 4'b0111, 6'b011010, 1); tick();
    chk("t4_stall_drop", a_st, 0);
    drive_a(0, 4'b0111, 6'b011010, 0);
    for (int k = 0; k < 6; k++) begin
      chk("t4_no_hilo", a_hw, 0);
      tick();
    end
    drive_a(1, 4'b0111, 6'b100000, 0); tick();
    chk("t4_add_after", a_alu, 3);
    chk("t4_add_valid", a_ov, 1);

    // Unsupported funct
    drive_a(1, 4'b0111, 6'b111111, 0); tick();
`ifdef ILLEGAL_TRAP_EN
    chk("t5_illegal_set", a_il, 1);
    chk("t5_code_held", a_alu, 3);
    chk("t5_no_valid", a_ov, 0);
    drive_a(1, 4'b0111, 6'b100100, 0); tick();
    chk("t5_illegal_sticky", a_il, 1);
    chk("t5_and_code", a_alu, 0);
`else
    chk("t5_illegal_tied", a_il, 0);
    chk("t5_code_reserved", a_alu, 9);
    chk("t5_valid", a_ov, 1);
    drive_a(1, 4'b1111, 6'b100000, 0); tick();
    chk("t5_upper_bit_code", a_alu, 9);
`endif

    // Asynchronous reset in the middle of a run
    drive_a(1, 4'b0111, 6'b011000, 0); tick();
    drive_a(0, 4'b0111, 6'b011000, 0); tick();
    chk("t6_running", a_st, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_code", a_alu, 9);
    chk("t6_async_stall", a_st, 0);
    chk("t6_async_start", a_ms, 0);
    chk("t6_async_valid", a_ov, 0);
    chk("t6_async_hilo", a_hw, 0);
    chk("t6_async_illegal", a_il, 0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t6_no_hilo", a_hw, 0);
      tick();
    end

    // MD_CYCLES=1: two stall cycles, then hilo_we
    b_dv = 1'b1; b_op = 3'b111; b_fn = 6'b011000; tick();
    b_dv = 1'b0;
    chk("b_code", b_alu, 8);
    chk("b_valid", b_ov, 1);
    chk("b_start", b_ms, 1);
    chk("b_stall1", b_st, 1);
    tick();
    chk("b_stall2", b_st, 1);
    chk("b_start_pulse", b_ms, 0);
    tick();
    chk("b_stall_end", b_st, 0);
    chk("b_hilo", b_hw, 1);
    tick();
    chk("b_hilo_pulse", b_hw, 0);
    chk("b_illegal", b_il, 0);

    // Random traffic on DUT A, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [3:0] op;
      logic [5:0] fn;
      r = int'($urandom_range(0, 15));
      if (r < 8)       op = 4'b0111;
      else if (r < 15) op = {1'b0, 3'($urandom_range(0, 7))};
      else             op = 4'($urandom_range(8, 15));
      if ($urandom_range(0, 4) == 0) fn = 6'($urandom_range(0, 63));
      else                           fn = fns[$urandom_range(0, 11)];
      drive_a(1'($urandom_range(0, 1)), op, fn, ($urandom_range(0, 9) == 0));
      if (i % 700 == 350) #2 reset = 1'b0;
      tick();
      reset = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
